lcd_testgen: RTL and testbench
==============================

LCD_TESTGEN -- requirements
Module: lcd_testgen

Interface
REQ-001 Parameters (name, default, meaning):
- LINE_CYCLES, 228: clk cycles per line; SHALL be at least 164.
- VIS_LINES, 144: lines carrying pixels per frame.
- TOTAL_LINES, 154: lines per frame, visible plus blank.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  sole clock.
- n_reset  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- mode  in  2  pattern: 0 solid, 1 vertical bars, 2 horizontal bars, 3 checker.
- color  in  2  solid-pattern pixel value.
- n_hsync/p_hsync, n_vsync/p_vsync, n_latch/p_latch, n_altsig/p_altsig, n_ctrl/p_ctrl, n_pclk/p_pclk  out  1 each  LCD-bus signal value for the negedge half (n_) and posedge half (p_) of the current cycle.
- n_px/p_px  out  2 each  pixel value per half.
- frame_start  out  1  one-cycle pulse at line 0, cycle 0.
- line  out  8  current line index.
- busy  out  1  state is not IDLE.

Function
REQ-003 All outputs SHALL be registered, and the block SHALL have no combinational input-to-output paths.
REQ-004 The state machine SHALL have states IDLE, RUN and SHUTDOWN; counters SHALL be col (0..LINE_CYCLES-1) and line (0..TOTAL_LINES-1).
REQ-005 In IDLE, all bus outputs SHALL be 0; when enable=1 the block SHALL move to RUN with col=0 and line=0, and the first RUN cycle SHALL be line 0, cycle 0.
REQ-006 Col SHALL wrap to 0 after LINE_CYCLES-1 and then increment line; line SHALL wrap to 0 after TOTAL_LINES-1.
REQ-007 Visible-line waveform in RUN (line < VIS_LINES), with n and p halves listed:
- col 0: hsync 1/1; pclk 0/1.
- col 1: hsync 1/1; pclk 0/1. This is a pclk fall during hsync, which starts a line.
- col 2: hsync 0/0; pclk 1/1. The hsync fall carries pixel 0.
- col 3..160: pclk 0/1. Each pclk fall carries pixels 1..158.
- col 161: pclk 1/1; latch 1/1.
- col 162: pclk 1/1; latch 0/0. The latch fall carries pixel 159.
- col ≥163: all signals 0.
REQ-008 Pixel k SHALL appear on n_px at col 2+k for k=0..158, and at col 162 for k=159; p_px SHALL equal n_px; px SHALL be 0 elsewhere.
REQ-009 Pixel values (x = k, y = line), using the mode and color registered at frame_start:
- mode 0: color.
- mode 1: x[4:3].
- mode 2: y[4:3].
- mode 3: {2{x[3]^y[3]}}.
REQ-010 Blank lines (line ≥ VIS_LINES) SHALL drive hsync, latch, pclk and px to 0 for the whole line.
REQ-011 vsync SHALL be 1/1 on line 0 for col 0..3 and 0 otherwise.
REQ-012 altsig SHALL equal 1/1 or 0/0 (n = p), and SHALL toggle at each frame_start.
REQ-013 ctrl SHALL be 1/1 throughout RUN.
REQ-014 Enable SHALL be sampled only on the last cycle of the last line:
- enable=1 continues into the next frame.
- enable=0 enters SHUTDOWN.
REQ-015 SHUTDOWN SHALL emit exactly one line with the REQ-007 waveform, with vsync=0, ctrl=0 and px=0, and then enter IDLE; enable SHALL be ignored during SHUTDOWN.
REQ-016 Changes to mode or color mid-frame SHALL take effect only at the next frame_start.
REQ-017 frame_start SHALL pulse in RUN only, and line SHALL read 0 in IDLE and SHUTDOWN.

Reset
REQ-018 While n_reset=0 (asynchronous assertion), the block SHALL be in IDLE, with col=0, line=0, every output 0, altsig=0, and registered mode/color 0.
REQ-019 Reset asserted mid-frame or mid-SHUTDOWN SHALL abort immediately, with no further pulses.
REQ-020 After n_reset deasserts, the block SHALL enter RUN only when enable=1 is sampled in IDLE.

Verification
REQ-021 Enable=1, mode=0, color=2, one line:
- frame_start at cycle 0 and vsync 1/1 for col 0..3.
- pclk fall with hsync high at col 1.
- hsync fall at col 2.
- 158 n-half pclk falls at col 3..160.
- latch fall at col 162.
- All 160 pixels equal 2.
REQ-022 With the block feeding lcd_uc1611 as downstream consumer, mode=1, for 2 frames: the consumer captures 160 pixels per line with repeating bar pattern 0,0..(8),1..(8),2..,3..; altsig toggles each frame; and the line count per frame is 154.
REQ-023 Enable dropped mid-frame:
- The frame completes to line 153.
- One SHUTDOWN line follows with ctrl 0/0 at the latch fall.
- busy falls, and all outputs are 0 afterwards.
REQ-024 Mode changed from 0 to 3 at line 50: the current frame stays solid, and the next frame shows the checker (pixel(8,0)=3, pixel(0,0)=0, pixel(8,8)=0).
REQ-025 Reset:
- n_reset pulsed low at line 10, col 100: all outputs are 0 within the same cycle.
- With enable held at 1 after release: line 0, col 0 occurs on the first cycle after release.
- altsig restarts at 0, then toggles to 1 at the first frame_start.
REQ-026 LINE_CYCLES=164: the blank tail is col 163 only, lines run back-to-back, and no pulse overlaps.

Source files
------------

// File: rtl/lcd_testgen.sv
// LCD bus test-pattern generator: one registered n-half/p-half value pair per
// clk cycle for each bus signal, sequenced line by line through whole frames.
module lcd_testgen #(
  parameter int LINE_CYCLES = 228,
  parameter int VIS_LINES   = 144,
  parameter int TOTAL_LINES = 154
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [1:0] color,
  output logic       n_hsync,
  output logic       p_hsync,
  output logic       n_vsync,
  output logic       p_vsync,
  output logic       n_latch,
  output logic       p_latch,
  output logic       n_altsig,
  output logic       p_altsig,
  output logic       n_ctrl,
  output logic       p_ctrl,
  output logic       n_pclk,
  output logic       p_pclk,
  output logic [1:0] n_px,
  output logic [1:0] p_px,
  output logic       frame_start,
  output logic [7:0] line,
  output logic       busy
);

  localparam int CW = $clog2(LINE_CYCLES);
  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_CYCLES - 1);
  localparam logic [CW-1:0] COL_0     = CW'(0);
  localparam logic [CW-1:0] COL_1     = CW'(1);
  localparam logic [CW-1:0] COL_2     = CW'(2);
  localparam logic [CW-1:0] COL_3     = CW'(3);
  localparam logic [CW-1:0] COL_160   = CW'(160);
  localparam logic [CW-1:0] COL_161   = CW'(161);
  localparam logic [CW-1:0] COL_162   = CW'(162);
  localparam logic [7:0]    LINE_LAST = 8'(TOTAL_LINES - 1);
  localparam logic [7:0]    LINE_VIS  = 8'(VIS_LINES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    SHUTDOWN = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [7:0]    r_line, w_line_nxt;
  logic [1:0]    r_mode, r_color;
  logic          r_alt;

  logic          w_in_run, w_wave, w_fs, w_alt_nxt;
  logic          w_hs, w_vs, w_latch, w_pclk_n, w_pclk_p, w_pix_en;
  logic [1:0]    w_x43, w_px;

  logic          r_hsync, r_vsync, r_latch, r_altsig, r_ctrl;
  logic          r_pclk_n, r_pclk_p, r_fs, r_busy;
  logic [1:0]    r_px;
  logic [7:0]    r_line_out;

  // Pattern value from bits [4:3] of the pixel column and line indices.
  function automatic logic [1:0] f_pixel(input logic [1:0] m, input logic [1:0] c,
                                         input logic [1:0] x43, input logic [1:0] y43);
    logic [1:0] v;
    case (m)
      2'd0:    v = c;
      2'd1:    v = x43;
      2'd2:    v = y43;
      2'd3:    v = {2{x43[0] ^ y43[0]}};
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // State and counter registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_col   <= COL_0;
      r_line  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_line  <= w_line_nxt;
    end
  end

  // Next state: enable is only looked at in IDLE and on the last cycle of a frame.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    case (r_state)
      IDLE: begin
        w_col_nxt  = COL_0;
        w_line_nxt = 8'd0;
        if (enable) w_state_nxt = RUN;
        else        w_state_nxt = IDLE;
      end
      RUN: begin
        if (r_col == COL_LAST) begin
          w_col_nxt = COL_0;
          if (r_line == LINE_LAST) begin
            w_line_nxt = 8'd0;
            if (enable) w_state_nxt = RUN;
            else        w_state_nxt = SHUTDOWN;
          end else begin
            w_line_nxt = r_line + 8'd1;
          end
        end else begin
          w_col_nxt = r_col + COL_1;
        end
      end
      SHUTDOWN: begin
        w_line_nxt = 8'd0;
        if (r_col == COL_LAST) begin
          w_col_nxt   = COL_0;
          w_state_nxt = IDLE;
        end else begin
          w_col_nxt = r_col + COL_1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_col_nxt   = COL_0;
        w_line_nxt  = 8'd0;
      end
    endcase
  end

  // Bus values for the cycle about to start, decoded from the next state and counters.
  always_comb begin
    w_hs     = 1'b0;
    w_latch  = 1'b0;
    w_pclk_n = 1'b0;
    w_pclk_p = 1'b0;
    w_pix_en = 1'b0;
    w_in_run = (w_state_nxt == RUN);
    w_wave   = (w_state_nxt == SHUTDOWN) || (w_in_run && (w_line_nxt < LINE_VIS));
    w_fs     = w_in_run && (w_line_nxt == 8'd0) && (w_col_nxt == COL_0);
    w_vs     = w_in_run && (w_line_nxt == 8'd0) && (w_col_nxt <= COL_3);
    if (w_wave) begin
      if (w_col_nxt <= COL_1) begin
        w_hs     = 1'b1;
        w_pclk_p = 1'b1;
      end else if (w_col_nxt == COL_2) begin
        w_pclk_n = 1'b1;
        w_pclk_p = 1'b1;
        w_pix_en = 1'b1;
      end else if (w_col_nxt <= COL_160) begin
        w_pclk_p = 1'b1;
        w_pix_en = 1'b1;
      end else if (w_col_nxt == COL_161) begin
        w_pclk_n = 1'b1;
        w_pclk_p = 1'b1;
        w_latch  = 1'b1;
      end else if (w_col_nxt == COL_162) begin
        w_pclk_n = 1'b1;
        w_pclk_p = 1'b1;
        w_pix_en = 1'b1;
      end else begin
        w_pix_en = 1'b0;
      end
    end else begin
      w_pix_en = 1'b0;
    end
    // Bits [4:3] of (col - 2); the borrow comes from col[2:0] < 2. Pixel 159 sits at col 162.
    if (w_col_nxt == COL_162) begin
      w_x43 = 2'b11;
    end else begin
      w_x43 = w_col_nxt[4:3] - {1'b0, (w_col_nxt[2:1] == 2'b00)};
    end
    if (w_in_run && w_pix_en) begin
      w_px = f_pixel(r_mode, r_color, w_x43, w_line_nxt[4:3]);
    end else begin
      w_px = 2'd0;
    end
    if (w_fs) w_alt_nxt = ~r_alt;
    else      w_alt_nxt = r_alt;
  end

  // Frame-latched pattern settings and the altsig phase.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_mode  <= 2'd0;
      r_color <= 2'd0;
      r_alt   <= 1'b0;
    end else begin
      if (w_fs) begin
        r_mode  <= mode;
        r_color <= color;
      end
      r_alt <= w_alt_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_hsync    <= 1'b0;
      r_vsync    <= 1'b0;
      r_latch    <= 1'b0;
      r_altsig   <= 1'b0;
      r_ctrl     <= 1'b0;
      r_pclk_n   <= 1'b0;
      r_pclk_p   <= 1'b0;
      r_px       <= 2'd0;
      r_fs       <= 1'b0;
      r_line_out <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      r_hsync    <= w_hs;
      r_vsync    <= w_vs;
      r_latch    <= w_latch;
      r_altsig   <= (w_state_nxt != IDLE) && w_alt_nxt;
      r_ctrl     <= w_in_run;
      r_pclk_n   <= w_pclk_n;
      r_pclk_p   <= w_pclk_p;
      r_px       <= w_px;
      r_fs       <= w_fs;
      r_line_out <= w_in_run ? w_line_nxt : 8'd0;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  assign n_hsync     = r_hsync;
  assign p_hsync     = r_hsync;
  assign n_vsync     = r_vsync;
  assign p_vsync     = r_vsync;
  assign n_latch     = r_latch;
  assign p_latch     = r_latch;
  assign n_altsig    = r_altsig;
  assign p_altsig    = r_altsig;
  assign n_ctrl      = r_ctrl;
  assign p_ctrl      = r_ctrl;
  assign n_pclk      = r_pclk_n;
  assign p_pclk      = r_pclk_p;
  assign n_px        = r_px;
  assign p_px        = r_px;
  assign frame_start = r_fs;
  assign line        = r_line_out;
  assign busy        = r_busy;

endmodule

// File: tb/tb_lcd_testgen.sv
// Randomized bench for lcd_testgen: per-cycle frame-position reference model plus
// a simple strobe-capturing consumer and frame-level timing checks.
module tb_lcd_testgen;
  localparam int LC  = 164;
  localparam int VIS = 18;
  localparam int TL  = 20;

  logic       clk = 1'b0;
  logic       n_reset, enable;
  logic [1:0] mode, color;
  logic       n_hsync, p_hsync, n_vsync, p_vsync, n_latch, p_latch;
  logic       n_altsig, p_altsig, n_ctrl, p_ctrl, n_pclk, p_pclk;
  logic [1:0] n_px, p_px;
  logic       frame_start, busy;
  logic [7:0] line;

  int checks = 0;
  int failures = 0;

  // reference model: state 0 idle, 1 run, 2 shutdown; position counted in cycles
  int         m_st, m_pos;
  logic [1:0] m_mode, m_color;
  logic       m_alt;

  // consumer and frame-timing observers
  logic prev_p_hs, prev_p_pclk, prev_p_latch, prev_alt;
  bit   cap_active, fs_valid;
  int   cap_n, fs_gap;

  lcd_testgen #(.LINE_CYCLES(LC), .VIS_LINES(VIS), .TOTAL_LINES(TL)) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable), .mode(mode), .color(color),
    .n_hsync(n_hsync), .p_hsync(p_hsync), .n_vsync(n_vsync), .p_vsync(p_vsync),
    .n_latch(n_latch), .p_latch(p_latch), .n_altsig(n_altsig), .p_altsig(p_altsig),
    .n_ctrl(n_ctrl), .p_ctrl(p_ctrl), .n_pclk(n_pclk), .p_pclk(p_pclk),
    .n_px(n_px), .p_px(p_px), .frame_start(frame_start), .line(line), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_pixel(input int k, input int y, input logic [1:0] md,
                                           input logic [1:0] c);
    case (md)
      2'd0:    return c;
      2'd1:    return 2'((k / 8) % 4);
      2'd2:    return 2'((y / 8) % 4);
      default: return (((k / 8) % 2) != ((y / 8) % 2)) ? 2'd3 : 2'd0;
    endcase
  endfunction

  function automatic logic [25:0] dut_vec();
    return {n_hsync, p_hsync, n_vsync, p_vsync, n_latch, p_latch, n_altsig, p_altsig,
            n_ctrl, p_ctrl, n_pclk, p_pclk, n_px, p_px, frame_start, line, busy};
  endfunction

  function automatic logic [25:0] exp_vec();
    int col, ln, k;
    logic hs, vs, la, alt, ctl, pcn, pcp, fs, bz;
    logic [1:0] px;
    logic [7:0] lo;
    col = m_pos % LC;
    ln  = (m_st == 1) ? (m_pos / LC) : 0;
    k   = -1;
    hs = 1'b0; la = 1'b0; pcn = 1'b0; pcp = 1'b0;
    if ((m_st == 2) || (m_st == 1 && ln < VIS)) begin
      if (col <= 1)        begin hs = 1'b1; pcp = 1'b1; end
      else if (col == 2)   begin pcn = 1'b1; pcp = 1'b1; k = 0; end
      else if (col <= 160) begin pcp = 1'b1; k = col - 2; end
      else if (col == 161) begin pcn = 1'b1; pcp = 1'b1; la = 1'b1; end
      else if (col == 162) begin pcn = 1'b1; pcp = 1'b1; k = 159; end
    end
    px  = (m_st == 1 && k >= 0) ? ref_pixel(k, ln, m_mode, m_color) : 2'd0;
    vs  = (m_st == 1 && ln == 0 && col <= 3);
    ctl = (m_st == 1);
    alt = (m_st != 0) ? m_alt : 1'b0;
    fs  = (m_st == 1 && m_pos == 0);
    lo  = 8'(ln);
    bz  = (m_st != 0);
    return {hs, hs, vs, vs, la, la, alt, alt, ctl, ctl, pcn, pcp, px, px, fs, lo, bz};
  endfunction

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_mode = 2'd0; m_color = 2'd0; m_alt = 1'b0;
  endtask

  task automatic start_frame();
    m_pos = 0; m_mode = mode; m_color = color; m_alt = ~m_alt;
  endtask

  task automatic model_step();
    if (!n_reset) begin
      model_reset();
    end else if (m_st == 0) begin
      if (enable) begin m_st = 1; start_frame(); end
    end else if (m_st == 1) begin
      m_pos++;
      if (m_pos == LC * TL) begin
        if (enable) start_frame();
        else begin m_st = 2; m_pos = 0; end
      end
    end else begin
      m_pos++;
      if (m_pos == LC) begin m_st = 0; m_pos = 0; end
    end
  endtask

  task automatic cap_pixel();
    logic [1:0] e;
    e = (m_st == 1) ? ref_pixel(cap_n, m_pos / LC, m_mode, m_color) : 2'd0;
    check_val("cap_px", 32'(n_px), 32'(e));
    cap_n++;
  endtask

  task automatic observe();
    check_val("bus", 32'(dut_vec()), 32'(exp_vec()));
    if (frame_start) begin
      if (fs_valid) begin
        check_val("frame_len", 32'(fs_gap), 32'(LC * TL));
        check_val("alt_toggle", 32'(n_altsig), 32'(!prev_alt));
      end
      fs_valid = 1'b1;
      fs_gap   = 0;
    end
    fs_gap++;
    if (!busy) fs_valid = 1'b0;
    prev_alt = n_altsig;
    if (cap_active && prev_p_latch && !n_latch) begin
      cap_pixel();
      check_val("cap_cnt", 32'(cap_n), 32'd160);
      cap_active = 1'b0;
    end else if (prev_p_hs && !n_hsync) begin
      cap_active = 1'b1;
      cap_n      = 0;
      cap_pixel();
    end else if (cap_active && prev_p_pclk && !n_pclk && !n_hsync) begin
      cap_pixel();
    end
    prev_p_hs    = p_hsync;
    prev_p_pclk  = p_pclk;
    prev_p_latch = p_latch;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    observe();
  endtask

  task automatic async_reset(input int hold, input logic en_after);
    n_reset = 1'b0;
    #1;
    check_val("async_rst", 32'(dut_vec()), 32'd0);
    model_reset();
    cap_active = 1'b0;
    fs_valid   = 1'b0;
    repeat (hold) cycle();
    enable  = en_after;
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset = 1'b0; enable = 1'b0; mode = 2'd0; color = 2'd0;
    model_reset();
    prev_p_hs = 1'b0; prev_p_pclk = 1'b0; prev_p_latch = 1'b0; prev_alt = 1'b0;
    cap_active = 1'b0; fs_valid = 1'b0; cap_n = 0; fs_gap = 0;

    repeat (3) cycle();
    n_reset = 1'b1;
    repeat (5) cycle();

    // solid color 2 frame, then switch to checker partway through it
    mode = 2'd0; color = 2'd2; enable = 1'b1;
    repeat (LC * 10 + 1) cycle();
    mode = 2'd3;
    repeat (LC * TL * 2) cycle();

    // drop enable mid-frame: finish frame, one shutdown line, then idle
    enable = 1'b0;
    repeat (LC * TL + LC + 20) cycle();

    // bars pattern, then an asynchronous reset mid-frame with enable held high
    mode = 2'd1; enable = 1'b1;
    repeat (LC * 3 + 50) cycle();
    async_reset(2, 1'b1);
    repeat (LC * TL + 10) cycle();

    // randomized traffic: pattern changes, enable drops, occasional resets
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        mode  = 2'($urandom);
        color = 2'($urandom);
      end
      if ($urandom_range(0, 1499) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 8999) == 0)
        async_reset(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
